// File: rtl/vote_pkg.sv
// Shared types and helpers for the vote tally block.
package vote_pkg;

  localparam int DEF_NUM_CAND = 4;
  localparam int DEF_CNT_W    = 8;
  localparam int MAX_CAND     = 16;

  typedef enum logic [1:0] {
    ST_VOTE    = 2'd0,
    ST_HOLD    = 2'd1,
    ST_DISPLAY = 2'd2
  } vote_state_e;

  // True when exactly one bit of v is set (v != 0 and v has no second bit).
  function automatic logic is_onehot(input logic [MAX_CAND-1:0] v);
    return (v != '0) && ((v & (v - MAX_CAND'(1))) == '0);
  endfunction

endpackage

// File: rtl/vote_leader_scan.sv
// Combinational max/argmax/tie scan over a flat bank of counters.
// The lowest index wins on ties; tie_o reports that the maximum is shared.
module vote_leader_scan
  import vote_pkg::*;
#(
  parameter int NUM_CAND = DEF_NUM_CAND,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int SEL_W    = $clog2(NUM_CAND)
) (
  input  logic [NUM_CAND*CNT_W-1:0] counts_flat_i,
  output logic [SEL_W-1:0]          max_idx_o,
  output logic                      tie_o
);

  logic [CNT_W-1:0] best;

  // Linear scan: a strictly larger count takes the lead and clears the tie,
  // an equal count only marks a tie so the earlier index is kept.
  always_comb begin
    best      = counts_flat_i[CNT_W-1:0];
    max_idx_o = '0;
    tie_o     = 1'b0;
    for (int i = 1; i < NUM_CAND; i++) begin
      if (counts_flat_i[i*CNT_W +: CNT_W] > best) begin
        best      = counts_flat_i[i*CNT_W +: CNT_W];
        max_idx_o = SEL_W'(i);
        tie_o     = 1'b0;
      end else if (counts_flat_i[i*CNT_W +: CNT_W] == best) begin
        tie_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vote_tally_ctrl.sv
// Vote tally controller: edge-detected one-hot presses, post-vote hold-off,
// saturating per-candidate counters, running total, registered leader scan
// and a selectable display readout.
// Handshake: vote_req is a level input; a vote is taken on the rising edge of
// a single button while in VOTE with mode=0. vote_ack / vote_err are one-cycle
// pulses in the cycle after the press and are mutually exclusive. There is no
// back-pressure: presses outside VOTE are dropped without any response.
module vote_tally_ctrl
  import vote_pkg::*;
#(
  parameter int NUM_CAND = DEF_NUM_CAND,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int HOLDOFF  = 16,
  parameter int SEL_W    = $clog2(NUM_CAND),
  parameter int TOT_W    = CNT_W + $clog2(NUM_CAND)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mode,
  input  logic [NUM_CAND-1:0]       vote_req,
  input  logic [SEL_W-1:0]          disp_sel,
  output logic [NUM_CAND*CNT_W-1:0] counts_flat,
  output logic [CNT_W-1:0]          disp_count,
  output logic [TOT_W-1:0]          total_votes,
  output logic [SEL_W-1:0]          leader_idx,
  output logic                      leader_tie,
  output logic                      leader_valid,
  output logic [NUM_CAND-1:0]       sat_flags,
  output logic                      vote_ack,
  output logic                      vote_err,
  output logic [1:0]                dbg_state
);

  localparam int HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  vote_state_e                      state_q, state_d;
  logic [HOLD_W-1:0]                hold_q, hold_d;
  logic [NUM_CAND-1:0]              prev_req_q;
  logic [NUM_CAND-1:0][CNT_W-1:0]   cnt_q, cnt_d;
  logic [TOT_W-1:0]                 total_q, total_d;
  logic [NUM_CAND-1:0]              sat_q, sat_d;
  logic                             ack_q, ack_d;
  logic                             err_q, err_d;
  logic [CNT_W-1:0]                 disp_q, disp_d;
  logic [SEL_W-1:0]                 lead_idx_q, scan_idx;
  logic                             lead_tie_q, scan_tie;
  logic                             lead_valid_q;

  logic [NUM_CAND-1:0]              rise;
  logic                             can_vote;
  logic                             rise_onehot;
  logic                             accept;

  // Press decode: rising edges only, accepted when one-hot in VOTE/voting mode.
  always_comb begin
    rise        = vote_req & ~prev_req_q;
    can_vote    = (state_q == ST_VOTE) && !mode;
    rise_onehot = is_onehot(MAX_CAND'(rise));
    accept      = can_vote && rise_onehot;
    ack_d       = accept;
    err_d       = can_vote && (rise != '0) && !rise_onehot;
  end

  // Counter bank: increment the pressed candidate unless already at max.
  always_comb begin
    cnt_d   = cnt_q;
    total_d = total_q;
    sat_d   = sat_q;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (accept && rise[i]) begin
        if (cnt_q[i] != CNT_MAX) begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
          total_d  = total_q + TOT_W'(1);
          if (cnt_q[i] == CNT_MAX - CNT_W'(1)) sat_d[i] = 1'b1;
        end else begin
          sat_d[i] = 1'b1;
        end
      end
    end
  end

  // Mode FSM: display overrides everything; HOLD counts down the hold-off.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    if (mode) begin
      state_d = ST_DISPLAY;
      hold_d  = '0;
    end else begin
      case (state_q)
        ST_VOTE: begin
          if (accept) begin
            state_d = ST_HOLD;
            hold_d  = HOLD_W'(HOLDOFF - 1);
          end
        end
        ST_HOLD: begin
          if (hold_q == '0) state_d = ST_VOTE;
          else              hold_d  = hold_q - HOLD_W'(1);
        end
        ST_DISPLAY: state_d = ST_VOTE;
        default:    state_d = ST_VOTE;
      endcase
    end
  end

  // Display readout: selected counter in display mode, zero otherwise.
  always_comb begin
    disp_d = '0;
    if (mode && (int'(disp_sel) < NUM_CAND)) disp_d = cnt_q[disp_sel];
  end

  vote_leader_scan #(
    .NUM_CAND (NUM_CAND),
    .CNT_W    (CNT_W),
    .SEL_W    (SEL_W)
  ) u_scan (
    .counts_flat_i (cnt_q),
    .max_idx_o     (scan_idx),
    .tie_o         (scan_tie)
  );

  // State registers; prev_req resets high so a button held through reset is not a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_VOTE;
      hold_q       <= '0;
      prev_req_q   <= '1;
      cnt_q        <= '0;
      total_q      <= '0;
      sat_q        <= '0;
      ack_q        <= 1'b0;
      err_q        <= 1'b0;
      disp_q       <= '0;
      lead_idx_q   <= '0;
      lead_tie_q   <= 1'b0;
      lead_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      prev_req_q   <= vote_req;
      cnt_q        <= cnt_d;
      total_q      <= total_d;
      sat_q        <= sat_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
      disp_q       <= disp_d;
      lead_idx_q   <= scan_idx;
      lead_tie_q   <= scan_tie;
      lead_valid_q <= (total_q != '0);
    end
  end

  assign counts_flat  = cnt_q;
  assign disp_count   = disp_q;
  assign total_votes  = total_q;
  assign leader_idx   = lead_idx_q;
  assign leader_tie   = lead_tie_q;
  assign leader_valid = lead_valid_q;
  assign sat_flags    = sat_q;
  assign vote_ack     = ack_q;
  assign vote_err     = err_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_vote_tally_ctrl.sv
// Bench for vote_tally_ctrl: directed presses, a behavioural tally model
// checked every cycle, and literal expectations at key points.
module tb_vote_tally_ctrl;
  import vote_pkg::*;

  localparam int NC    = 4;
  localparam int CNT_W = 8;
  localparam int HOLD  = 16;
  localparam int SEL_W = 2;
  localparam int TOT_W = 10;
  localparam int CMAX  = (1 << CNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                   mode;
  logic [NC-1:0]          vote_req;
  logic [SEL_W-1:0]       disp_sel;
  logic [NC*CNT_W-1:0]    counts_flat;
  logic [CNT_W-1:0]       disp_count;
  logic [TOT_W-1:0]       total_votes;
  logic [SEL_W-1:0]       leader_idx;
  logic                   leader_tie;
  logic                   leader_valid;
  logic [NC-1:0]          sat_flags;
  logic                   vote_ack;
  logic                   vote_err;
  logic [1:0]             dbg_state;

  vote_tally_ctrl #(.NUM_CAND(NC), .CNT_W(CNT_W), .HOLDOFF(HOLD)) dut (
    .clk          (clk),
    .rst          (rst),
    .mode         (mode),
    .vote_req     (vote_req),
    .disp_sel     (disp_sel),
    .counts_flat  (counts_flat),
    .disp_count   (disp_count),
    .total_votes  (total_votes),
    .leader_idx   (leader_idx),
    .leader_tie   (leader_tie),
    .leader_valid (leader_valid),
    .sat_flags    (sat_flags),
    .vote_ack     (vote_ack),
    .vote_err     (vote_err),
    .dbg_state    (dbg_state)
  );

  int n_checks = 0;
  int n_bad    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Votes are tallied as plain integers; the hold-off is a count of cycles
  // during which presses are dropped. Registered outputs are taken from the
  // tally as it stood before the current edge.
  int            m_cnt [NC];
  logic [NC-1:0] m_sat;
  logic [NC-1:0] m_prev;
  logic [NC-1:0] m_rise;
  bit            m_in_disp;
  int            m_hold;
  bit            m_ack, m_err;
  int            m_lidx;
  bit            m_ltie, m_lval;
  int            m_disp;
  bit            model_ready = 1'b0;
  int            mx, holders, sum, a_idx;
  bit            votable, accepted;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NC; i++) m_cnt[i] = 0;
      m_sat = '0; m_prev = '1; m_in_disp = 0; m_hold = 0;
      m_ack = 0; m_err = 0; m_lidx = 0; m_ltie = 0; m_lval = 0; m_disp = 0;
      model_ready = 1'b1;
    end else begin
      mx = -1; a_idx = 0; holders = 0; sum = 0;
      for (int i = 0; i < NC; i++) begin
        sum += m_cnt[i];
        if (m_cnt[i] > mx) begin mx = m_cnt[i]; m_lidx = i; end
      end
      for (int i = 0; i < NC; i++) if (m_cnt[i] == mx) holders++;
      m_ltie = (holders > 1);
      m_lval = (sum != 0);
      m_disp = (mode && int'(disp_sel) < NC) ? m_cnt[disp_sel] : 0;

      m_rise   = vote_req & ~m_prev;
      m_prev   = vote_req;
      votable  = !m_in_disp && (m_hold == 0) && !mode;
      accepted = 0; m_ack = 0; m_err = 0;
      if (votable && m_rise != '0) begin
        if ($countones(m_rise) == 1) begin
          for (int i = 0; i < NC; i++) if (m_rise[i]) a_idx = i;
          accepted = 1; m_ack = 1;
          if (m_cnt[a_idx] < CMAX) m_cnt[a_idx]++;
          if (m_cnt[a_idx] == CMAX) m_sat[a_idx] = 1'b1;
        end else begin
          m_err = 1;
        end
      end

      if (mode) begin m_in_disp = 1; m_hold = 0; end
      else if (m_in_disp) m_in_disp = 0;
      else if (m_hold > 0) m_hold--;
      else if (accepted) m_hold = HOLD;
    end
  end

  // ---------------- scoreboard compare ----------------
  logic [NC*CNT_W-1:0] exp_flat;
  int                  exp_total;
  logic [1:0]          exp_state;

  always @(negedge clk) begin
    if (!rst && model_ready) begin
      exp_total = 0;
      for (int i = 0; i < NC; i++) begin
        exp_flat[i*CNT_W +: CNT_W] = CNT_W'(m_cnt[i]);
        exp_total += m_cnt[i];
      end
      exp_state = m_in_disp ? ST_DISPLAY : ((m_hold > 0) ? ST_HOLD : ST_VOTE);
      chk("cyc_counts", counts_flat, exp_flat);
      chk("cyc_total",  total_votes, exp_total);
      chk("cyc_sat",    sat_flags, m_sat);
      chk("cyc_ack",    vote_ack, m_ack);
      chk("cyc_err",    vote_err, m_err);
      chk("cyc_lidx",   leader_idx, m_lidx);
      chk("cyc_ltie",   leader_tie, m_ltie);
      chk("cyc_lval",   leader_valid, m_lval);
      chk("cyc_disp",   disp_count, m_disp);
      chk("cyc_state",  dbg_state, exp_state);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; vote_req = '0; mode = 1'b0; disp_sel = '0;
    idle(2);
    rst = 1'b0;
    idle(1);
  endtask

  task automatic press(input logic [NC-1:0] v);
    vote_req = v;
    @(negedge clk);
    vote_req = '0;
    @(negedge clk);
  endtask

  task automatic press_wait(input logic [NC-1:0] v);
    press(v);
    idle(HOLD);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- directed test sequence ----------------
  initial begin
    rst = 1'b1; mode = 1'b0; vote_req = 4'b0001; disp_sel = '0;
    #1;
    chk("rst_counts", counts_flat, 0);
    chk("rst_ack",    vote_ack, 0);
    chk("rst_state",  dbg_state, ST_VOTE);
    chk("rst_tie",    leader_tie, 0);

    // 1: button held through reset is not counted; fresh press is.
    idle(3);
    rst = 1'b0;
    idle(3);
    chk("t1_held_counts", counts_flat, 0);
    chk("t1_zero_tie",    leader_tie, 1);
    chk("t1_zero_valid",  leader_valid, 0);
    vote_req = '0;
    @(negedge clk);
    vote_req = 4'b0001;
    @(negedge clk);
    chk("t1_ack",   vote_ack, 1);
    chk("t1_cnt0",  counts_flat[7:0], 1);
    chk("t1_total", total_votes, 1);
    vote_req = '0;
    @(negedge clk);
    chk("t1_ack_drop", vote_ack, 0);
    chk("t1_lidx",     leader_idx, 0);
    chk("t1_ltie",     leader_tie, 0);
    chk("t1_lval",     leader_valid, 1);

    // 2: press during hold-off is dropped silently.
    do_reset();
    vote_req = 4'b0100;
    @(negedge clk);
    vote_req = '0;
    idle(2);
    vote_req = 4'b0010;
    @(negedge clk);
    chk("t2_hold_err", vote_err, 0);
    chk("t2_hold_ack", vote_ack, 0);
    vote_req = '0;
    idle(20);
    chk("t2_after_hold", counts_flat, 32'h0001_0000);
    press(4'b0010);
    chk("t2_repress", counts_flat, 32'h0001_0100);

    // 3: multi-hot press is rejected.
    do_reset();
    vote_req = 4'b0110;
    @(negedge clk);
    chk("t3_err",    vote_err, 1);
    chk("t3_ack",    vote_ack, 0);
    chk("t3_counts", counts_flat, 0);
    chk("t3_state",  dbg_state, ST_VOTE);
    vote_req = '0;
    @(negedge clk);
    chk("t3_err_drop", vote_err, 0);

    // 4: saturation of candidate 3.
    do_reset();
    for (int k = 0; k < 255; k++) press_wait(4'b1000);
    chk("t4_cnt3_255", counts_flat[31:24], 255);
    chk("t4_sat",      sat_flags, 4'b1000);
    vote_req = 4'b1000;
    @(negedge clk);
    chk("t4_ack_256", vote_ack, 1);
    vote_req = '0;
    idle(HOLD);
    chk("t4_cnt3_hold", counts_flat[31:24], 255);
    chk("t4_total",     total_votes, 255);
    chk("t4_sat_kept",  sat_flags, 4'b1000);

    // 5: tie between 0 and 2, display readout, presses ignored in display.
    do_reset();
    for (int k = 0; k < 5; k++) press_wait(4'b0001);
    for (int k = 0; k < 3; k++) press_wait(4'b0010);
    for (int k = 0; k < 5; k++) press_wait(4'b0100);
    mode = 1'b1; disp_sel = 2'd2;
    idle(2);
    chk("t5_disp", disp_count, 5);
    chk("t5_lidx", leader_idx, 0);
    chk("t5_ltie", leader_tie, 1);
    chk("t5_tot",  total_votes, 13);
    disp_sel = 2'd1;
    idle(1);
    chk("t5_disp1", disp_count, 3);
    press(4'b0001);
    idle(2);
    chk("t5_ignored", counts_flat[7:0], 5);
    mode = 1'b0;
    idle(2);
    chk("t5_disp_off", disp_count, 0);

    // 6: display aborts hold-off; return to voting accepts immediately.
    do_reset();
    press(4'b0001);
    chk("t6_in_hold", dbg_state, ST_HOLD);
    mode = 1'b1;
    idle(2);
    mode = 1'b0;
    @(negedge clk);
    chk("t6_vote", dbg_state, ST_VOTE);
    press(4'b0010);
    chk("t6_counts", counts_flat, 32'h0000_0101);

    // Reset mid-hold clears everything at once.
    rst = 1'b1;
    #1;
    chk("t6_rst_counts", counts_flat, 0);
    chk("t6_rst_total",  total_votes, 0);
    chk("t6_rst_state",  dbg_state, ST_VOTE);
    @(negedge clk);
    rst = 1'b0;
    idle(3);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/vote_tally_ctrl.md
Name: vote_tally_ctrl

Overview:
Parametrised successor to the fixed 4-candidate vote counter. Counts votes for NUM_CAND candidates with configurable counter width, and adds the following:
- edge-detected single-count presses
- rejection of multi-candidate presses
- a post-vote hold-off window
- saturating counters
- a running total, leader/tie detection and a selectable display readout
Sits between the ballot button debouncers and the display/7-seg driver.

Parameters:
NUM_CAND, 4, number of candidates (2..16)
CNT_W, 8, width of each per-candidate counter
HOLDOFF, 16, cycles after an accepted vote during which new presses are ignored (>=1)
SEL_W, $clog2(NUM_CAND), width of display select (derived, do not override)
TOT_W, CNT_W+$clog2(NUM_CAND), width of total counter (derived)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
mode  in  1  0 = voting, 1 = display
vote_req  in  NUM_CAND  level vote buttons, bit i = candidate i
disp_sel  in  SEL_W  candidate index for disp_count
counts_flat  out  NUM_CAND*CNT_W  all counters, candidate i at [i*CNT_W +: CNT_W]
disp_count  out  CNT_W  registered count of disp_sel candidate
total_votes  out  TOT_W  sum of all counters
leader_idx  out  SEL_W  lowest index holding the maximum count
leader_tie  out  1  more than one candidate holds the maximum
leader_valid  out  1  total_votes != 0
sat_flags  out  NUM_CAND  bit i set once counter i has saturated
vote_ack  out  1  one-cycle pulse, vote accepted
vote_err  out  1  one-cycle pulse, vote rejected as multi-hot

Behaviour:
- Reset (async assert, sync-to-clk deassert by upstream):
  - all counters, total, sat_flags, disp_count, leader_* and pulses = 0
  - state = VOTE
  - prev_req = all ones, so a button held through reset is not counted
- Edge detect:
  - rise = vote_req & ~prev_req
  - prev_req <= vote_req every cycle in every state
- FSM states: VOTE, HOLD, DISPLAY.
  - Any state, mode=1 -> DISPLAY next cycle. An active HOLD is aborted and the hold counter cleared.
  - DISPLAY, mode=0 -> VOTE.
  - VOTE, accepted vote -> HOLD, hold counter loaded with HOLDOFF-1.
  - HOLD, counter==0 -> VOTE; otherwise decrement.
- Acceptance, only in state VOTE with mode=0:
  - rise one-hot -> accepted.
  - rise with >=2 bits -> vote_err=1 next cycle, no counter changes, stay VOTE.
  - rise==0 -> nothing.
- Rises in HOLD or DISPLAY are ignored silently: no err, no ack.
- Accepted vote for candidate i, registered 1-cycle latency:
  - if count[i] < 2^CNT_W-1: count[i] +1, total +1, vote_ack=1.
  - if count[i] is already at max: count and total unchanged, sat_flags[i] stays/sets 1, vote_ack=1.
  - HOLD is entered in both cases.
- sat_flags[i] sets on the increment that reaches max and is cleared only by rst.
- total_votes always equals the sum of counts_flat and never wraps.
- Leader logic: combinational scan of the counters, registered. Outputs lag counters by 1 cycle.
  - Ties resolve to the lowest index for leader_idx, with leader_tie=1.
  - All-zero counts: leader_idx=0, leader_tie=1, leader_valid=0.
- disp_count is registered:
  - = count[disp_sel] when mode=1, else 0.
  - disp_sel >= NUM_CAND -> 0.
- vote_ack and vote_err are never both 1 in the same cycle.
- Reset asserted mid-HOLD or mid-count clears everything immediately. No partial increment survives.

Decomposition:
- Shared package vote_pkg:
  - state enum (VOTE/HOLD/DISPLAY)
  - onehot-check helper function
  - defaults for NUM_CAND/CNT_W
- One natural sub-module, vote_leader_scan: parametrised max/argmax/tie scan over counts_flat, purely combinational. Parent registers its outputs.

Test Plan:
1. rst pulse with vote_req=4'b0001 held -> after release, counts all 0, no ack. Release and repress bit0 -> count0=1, total=1, ack 1 cycle later, leader_idx=0, leader_tie=0.
2. Press cand2, then press cand1 3 cycles later (HOLDOFF=16) -> only count2=1, cand1 ignored, no err. Repress cand1 after 16 cycles -> count1=1.
3. Rise 4'b0110 in VOTE -> vote_err=1 for one cycle, all counts unchanged, state stays VOTE.
4. CNT_W=8: 256 accepted presses on cand3 -> count3=255, sat_flags[3]=1, total=255, ack still pulses on the 256th.
5. count0=5, count2=5, count1=3, mode=1, disp_sel=2 -> disp_count=5, leader_idx=0, leader_tie=1. Votes pressed in DISPLAY are ignored.
6. mode=1 asserted during HOLD, then returned to 0 -> state VOTE immediately. A fresh press is accepted without waiting for the remaining hold-off.
